// File: rtl/sha256_padder.sv
// sha256_padder
//   Message fetch and padding front end for the SHA-256 compression stage.
//   On start, reads the raw message (word addressed) from memory, formats
//   each word to big-endian, appends the SHA-256 padding (0x80 byte, zero
//   fill, 64-bit bit length) and streams 16 schedule words per 512-bit block
//   over a valid/ready handshake. Memory is only ever read.
//
// Build option:
//   SHA256_PADDER_BSWAP_EN  defined: memory holds little-endian words, each
//                           read word is byte swapped before use.
//                           undefined: memory words are already big-endian.
//
// Ports:
//   clk            clock (also the memory clock)
//   reset_n        asynchronous active-low reset
//   start          one-cycle request, sampled only while idle
//   message_addr   word address of the first message word (bits [15:0] used)
//   size           message length in bytes
//   busy           high from the cycle after start is accepted until done
//   done           one-cycle pulse after the final word is accepted
//   mem_addr       memory read address
//   mem_read_data  memory read data, valid one cycle after mem_addr
//   w_valid        schedule word valid
//   w_ready        downstream accepts the schedule word
//   w_data         schedule word, big-endian
//   w_idx          word index within the current block (0..15)
//   w_last_block   the current word belongs to the final block

module sha256_padder (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] size,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  input  logic [31:0] mem_read_data,
  output logic        w_valid,
  input  logic        w_ready,
  output logic [31:0] w_data,
  output logic [3:0]  w_idx,
  output logic        w_last_block
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    EMIT = 3'd3,
    DONE = 3'd4
  } state_t;

  // Convert a memory word to big-endian byte order.
  function automatic logic [31:0] fmt_word(input logic [31:0] d);
`ifdef SHA256_PADDER_BSWAP_EN
    fmt_word = {d[7:0], d[15:8], d[23:16], d[31:24]};
`else
    fmt_word = d;
`endif
  endfunction

  state_t      state_r;
  logic [15:0] base_r;
  logic [31:0] len_r;
  logic [31:0] g_r;

  logic [32:0] sum_s;
  logic [31:0] last_g_s;
  logic [31:0] nb_s;
  logic [1:0]  rem_s;
  logic [31:0] rd_words_s;
  logic [31:0] g_next_s;
  logic        needs_read_s;
  logic        next_read_s;
  logic        last_blk_s;
  logic [31:0] fd_s;
  logic [31:0] data_word_s;
  logic [31:0] gen_word_s;

  // Upper address bits are architecturally ignored.
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^message_addr[31:16];

  // Word classification and padding words derived from the latched length.
  always_comb begin
    sum_s      = {1'b0, len_r} + 33'd8;
    // T-1 where T = 16 * (((len + 8) >> 6) + 1)
    last_g_s   = 32'((sum_s >> 6) << 4) + 32'd15;
    nb_s       = {2'b00, len_r[31:2]};
    rem_s      = len_r[1:0];
    // Words that touch memory: all full words plus a trailing partial word.
    rd_words_s = nb_s + {31'd0, (rem_s != 2'd0)};
    g_next_s   = g_r + 32'd1;
    needs_read_s = (g_r < rd_words_s);
    next_read_s  = (g_next_s < rd_words_s);
    last_blk_s   = (g_r >= (last_g_s - 32'd15));
    fd_s         = fmt_word(mem_read_data);

    // Word built from memory: full data word or the partial word that
    // carries the 0x80 marker right after the last message byte.
    if (g_r < nb_s) begin
      data_word_s = fd_s;
    end else begin
      case (rem_s)
        2'd1:    data_word_s = (fd_s & 32'hFF00_0000) | 32'h0080_0000;
        2'd2:    data_word_s = (fd_s & 32'hFFFF_0000) | 32'h0000_8000;
        2'd3:    data_word_s = (fd_s & 32'hFFFF_FF00) | 32'h0000_0080;
        default: data_word_s = 32'h8000_0000;
      endcase
    end

    // Word generated without memory: marker word, length words or zero fill.
    if (g_r == nb_s) begin
      gen_word_s = 32'h8000_0000;
    end else if (g_r == last_g_s) begin
      gen_word_s = {len_r[28:0], 3'b000};
    end else if (g_r == (last_g_s - 32'd1)) begin
      gen_word_s = {29'd0, len_r[31:29]};
    end else begin
      gen_word_s = 32'd0;
    end
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      base_r       <= 16'd0;
      len_r        <= 32'd0;
      g_r          <= 32'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      mem_addr     <= 16'd0;
      w_valid      <= 1'b0;
      w_data       <= 32'd0;
      w_idx        <= 4'd0;
      w_last_block <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            base_r   <= message_addr[15:0];
            len_r    <= size;
            g_r      <= 32'd0;
            mem_addr <= message_addr[15:0];
            busy     <= 1'b1;
            state_r  <= ADDR;
          end else begin
            state_r  <= IDLE;
          end
        end
        ADDR: begin
          w_idx        <= g_r[3:0];
          w_last_block <= last_blk_s;
          if (needs_read_s) begin
            state_r <= DATA;
          end else begin
            w_data  <= gen_word_s;
            w_valid <= 1'b1;
            state_r <= EMIT;
          end
        end
        DATA: begin
          w_data  <= data_word_s;
          w_valid <= 1'b1;
          state_r <= EMIT;
        end
        EMIT: begin
          if (w_ready) begin
            w_valid <= 1'b0;
            if (g_r == last_g_s) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_r <= DONE;
            end else begin
              g_r <= g_next_s;
              // The address only moves for words that are actually read,
              // so a message with no data never disturbs the memory port.
              if (next_read_s) begin
                mem_addr <= base_r + g_next_s[15:0];
              end else begin
                mem_addr <= mem_addr;
              end
              state_r <= ADDR;
            end
          end else begin
            state_r <= EMIT;
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          w_valid <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
